// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types for the pipeline register stage. The occupancy
//                count doubles as the control state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Number of beats held by the stage; also the control state.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/en_reg.sv
`default_nettype none
// ============================================================================
//  Module      : en_reg
//  Description : WIDTH-bit data register with asynchronous active-high reset
//                to RESET_VALUE, synchronous clear (wins over load) and load
//                enable.
//  Ports       : clk, reset  - clock, async active-high reset
//                clr         - synchronous clear to RESET_VALUE
//                en          - load d on the next rising edge
//                d / q       - data in / registered data out
//  Revision    : 1.0 - initial release
// ============================================================================
module en_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = RESET_VALUE;
        end else if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : en_reg
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Pipeline register stage with valid/ready handshake, optional
//                skid entry (SKID=1, registered in_ready) and synchronous
//                flush. One cycle latency, one beat per cycle throughput,
//                FIFO order.
//  Ports       : clk, reset            - clock, async active-high reset
//                flush                 - squash all held beats at the edge
//                in_valid/in_ready/in_data    - upstream handshake + payload
//                out_valid/out_ready/out_data - downstream handshake + payload
//                occ                   - number of beats held (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               SKID        = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    occ_t             occ_d;
    occ_t             occ_q;
    logic             accept;
    logic             pop;
    logic             main_load;
    logic             main_from_skid;
    logic             skid_load;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign out_valid = (occ_q != OCC_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next occupancy and register load strobes. With SKID=0, in_ready in
    // state ONE equals out_ready, so accept without pop cannot occur there and
    // the FULL branch is never reached.
    always_comb begin
        occ_d          = occ_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (occ_q)
            OCC_EMPTY: begin
                if (accept) begin
                    occ_d     = OCC_ONE;
                    main_load = 1'b1;
                end
            end
            OCC_ONE: begin
                if (accept && pop) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    occ_d     = OCC_FULL;
                    skid_load = 1'b1;
                end else if (pop) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    occ_d          = OCC_ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
        // Flush discards everything, including a beat accepted this cycle;
        // the data registers are cleared by their own clear input.
        if (flush) begin
            occ_d = OCC_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= OCC_EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    en_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .en    (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_d;
            logic in_ready_q;

            en_reg #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_skid (
                .clk   (clk),
                .reset (reset),
                .clr   (flush),
                .en    (skid_load),
                .d     (in_data),
                .q     (skid_q)
            );

            // Registered ready: derived from next occupancy so there is no
            // combinational path from out_ready to in_ready.
            assign in_ready_d = (occ_d != OCC_FULL);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_no_skid
            logic unused_skid_load;

            assign unused_skid_load = skid_load;
            assign skid_q           = RESET_VALUE;
            assign in_ready         = ~out_valid | out_ready;
        end
    endgenerate

    assign out_data = main_q;
    assign occ      = occ_q;

endmodule : pipe_stage_reg
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline register stage for the processor datapath.
- Carries a WIDTH-bit payload from one stage to the next with a valid/ready handshake, an optional skid entry for full throughput under back-pressure, and a synchronous flush for branch/exception squash.
- Sits between datapath stages (fetch/decode/execute/writeback).
- Replaces the plain 8-bit always-load register wherever stall or squash is required.

Parameters:
- WIDTH, 8, payload width in bits (≥1).
- RESET_VALUE, 0, value loaded into the data registers on reset and flush (WIDTH bits).
- SKID, 1, 1 = two-entry skid slice with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all held beats.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  downstream beat valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  downstream payload.
- occ  output  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-high, port name reset.
- On reset assertion, immediately and independent of clk:
  - occ=0, out_valid=0.
  - main and skid data = RESET_VALUE, so out_data=RESET_VALUE.
  - in_ready=1 for SKID=1; in_ready=1 for SKID=0, since out_valid=0.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - in_data is sampled only on accept.
  - in_valid may not depend on in_ready.
  - out_valid, once high, stays high with stable out_data until pop or flush.
- Latency: a beat accepted at edge N appears on out_data/out_valid after edge N (1 cycle).
- Throughput: 1 beat/cycle sustained while out_ready=1. FIFO ordering is preserved.
- SKID=1 state machine (occ encodes state):
  - EMPTY (0):
    - accept -> ONE, main<=in_data.
  - ONE (1):
    - accept & pop -> ONE, main<=in_data.
    - accept & !pop -> FULL, skid<=in_data.
    - pop & !accept -> EMPTY.
    - else hold.
  - FULL (2): accept impossible, since in_ready=0.
    - pop -> ONE, main<=skid.
    - else hold.
  - in_ready is a register output equal to (next occ != 2). No combinational path from out_ready to in_ready.
  - out_valid = (occ != 0). out_data = main.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - accept -> main<=in_data, occ=1.
  - pop & !accept -> occ=0.
  - occ never exceeds 1.
- Flush (highest priority after reset):
  - At the edge with flush=1: occ<=0, out_valid<=0, main and skid <=RESET_VALUE.
  - A beat accepted in the flush cycle is discarded; it still counts as consumed upstream.
  - A pop in the flush cycle is a valid transfer downstream; the downstream stage decides whether to squash it.
  - SKID=1: in_ready<=1 after flush.
- Data hold: when out_valid=0, out_data holds its last value (RESET_VALUE after reset/flush). Verification does not check out_data while out_valid=0.
- Reset mid-operation: all held beats are lost and no beat emerges afterwards. After reset deasserts, operation resumes from EMPTY on the first rising edge.
- Width: no arithmetic. Payload is passed bit-exact at any WIDTH.

Decomposition:
- Shared package pipe_pkg:
  - occ state encoding OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_FULL=2'd2.
  - Typedef occ_t.
- One natural sub-module: en_reg, a WIDTH-bit register with async active-high reset to RESET_VALUE, load enable and synchronous clear.
  - Instantiate twice: main and skid (skid omitted via generate when SKID=0).
- Control state machine stays in pipe_stage_reg.

Test Plan:
- Reset/idle: assert reset mid-cycle with clk stopped -> out_valid=0, occ=0, out_data=RESET_VALUE (e.g. 8'h00) immediately; after release, in_ready=1.
- Streaming: SKID=1, out_ready=1, send 8'h11, 8'h22, 8'h33 on consecutive cycles -> same values on out_data one cycle later, back-to-back, occ stays 1.
- Back-pressure: out_ready=0, send 8'hA1, 8'hA2 -> occ=2, in_ready=0, out_data=8'hA1 held. Then out_ready=1 for 2 cycles -> pops A1 then A2, in_ready back to 1, no beat lost or duplicated.
- Flush while full: occ=2 (8'hB1, 8'hB2), flush=1 with in_valid=1 carrying 8'hB3 -> next cycle occ=0, out_valid=0, out_data=RESET_VALUE; B3 never appears downstream.
- SKID=0, WIDTH=32: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. out_ready=1 with in_valid=1 (32'hDEADBEEF) -> pop and accept in one cycle, occ stays 1.
- Random: constrained-random in_valid/out_ready/flush (flush 2%) at WIDTH=13 for 10k cycles against a queue scoreboard -> order preserved, occ matches model, out_valid/out_data stable while stalled.
